// File: rtl/ifetch_predict_pkg.sv
// Shared definitions for the instruction-fetch / branch-prediction slice.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package ifetch_predict_pkg;

    // Opcode field values (instr[31:26]) recognised by the fetch predecoder
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    // Branch strategy selected by bp_mode
    typedef enum logic [1:0] {
        BP_NOT_TAKEN    = 2'b00,
        BP_STATIC_TAKEN = 2'b01,
        BP_DELAY_SLOT   = 2'b10,
        BP_DYNAMIC      = 2'b11
    } bp_mode_e;

    // 2-bit saturating history counter; MSB is the taken prediction
    typedef logic [1:0] bht_ctr_t;
    localparam bht_ctr_t BHT_WEAK_NT = 2'b01;

    function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11) begin
            nxt = ctr + 2'd1;
        end else if (!taken && ctr != 2'b00) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ifetch_predict_bht.sv
// Table of 2-bit saturating branch-history counters.
// Latency: combinational read of the counter MSB; updates land on the next edge.
// Backpressure: none; one read and one update per cycle, read returns pre-update value.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_rd_idx -> o_rd_taken
//        prediction; i_upd_en/i_upd_idx/i_upd_taken train one counter per cycle.
module bht_2bit
    import ifetch_predict_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [$clog2(ENTRIES)-1:0] i_rd_idx,
    output logic                       o_rd_taken,
    input  logic                       i_upd_en,
    input  logic [$clog2(ENTRIES)-1:0] i_upd_idx,
    input  logic                       i_upd_taken
);

    bht_ctr_t r_ctr [ENTRIES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= BHT_WEAK_NT;
            end
        end else if (i_upd_en) begin
            r_ctr[i_upd_idx] <= bht_next(r_ctr[i_upd_idx], i_upd_taken);
        end
    end

    // Read straight from the array: a same-cycle update is not forwarded
    assign o_rd_taken = r_ctr[i_rd_idx][1];

endmodule

// File: rtl/ifetch_predict.sv
// Fetch stage: PC register, beq/j predecode + prediction, IF/ID register, EX redirect.
// Latency: instruction at pc appears on ifir one edge later; EX mispredict redirects pc next edge.
// Backpressure: stall holds pc and IF/ID; a mispredict overrides stall.
// Ports: clk/rst (async active-low); bp_mode strategy; imem_addr/imem_rdata fetch port;
//        ex_br_* resolution from EX; pc, ifir, id_pc4, id_pred_taken to ID; flush_id to
//        ID/EX; mispredict_cnt saturating statistic.
module ifetch_predict
    import ifetch_predict_pkg::*;
#(
    parameter int          BHT_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  bp_mode,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        ex_br_valid,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_br_pc,
    input  logic [31:0] ex_br_target,
    input  logic        ex_pred_taken,
    output logic [31:0] pc,
    output logic [31:0] ifir,
    output logic [31:0] id_pc4,
    output logic        id_pred_taken,
    output logic        flush_id,
    output logic [15:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [31:0] r_pc;
    logic [31:0] r_ifir;
    logic [31:0] r_id_pc4;
    logic        r_id_pred;
    logic [15:0] r_mis_cnt;

    logic [31:0] w_pc4;
    logic [5:0]  w_opcode;
    logic        w_is_beq;
    logic        w_is_j;
    logic [31:0] w_j_target;
    logic [31:0] w_beq_target;
    logic        w_bht_taken;
    logic        w_beq_pred;
    logic        w_beq_redirect;
    logic [31:0] w_next_pc;
    logic        w_mispredict;
    logic [31:0] w_fix_pc;
    logic        w_bht_upd;

    assign w_pc4        = r_pc + 32'd4;
    assign w_opcode     = imem_rdata[31:26];
    assign w_is_beq     = (w_opcode == OP_BEQ);
    assign w_is_j       = (w_opcode == OP_J);
    assign w_j_target   = {w_pc4[31:28], imem_rdata[25:0], 2'b00};
    assign w_beq_target = w_pc4 + {{14{imem_rdata[15]}}, imem_rdata[15:0], 2'b00};

    // Static direction for beq; delay-slot mode fetches straight-line like not-taken
    always_comb begin
        w_beq_pred = 1'b0;
        case (bp_mode)
            BP_STATIC_TAKEN: w_beq_pred = 1'b1;
            BP_DYNAMIC:      w_beq_pred = w_bht_taken;
            default:         w_beq_pred = 1'b0;
        endcase
    end

    assign w_beq_redirect = w_is_beq && w_beq_pred;
    assign w_next_pc      = w_is_j         ? w_j_target   :
                            w_beq_redirect ? w_beq_target : w_pc4;

    assign w_mispredict = ex_br_valid && (ex_br_taken != ex_pred_taken);
    assign w_fix_pc     = ex_br_taken ? ex_br_target : (ex_br_pc + 32'd4);
    // In delay-slot mode the instruction now in ID is the architectural slot and survives
    assign flush_id     = w_mispredict && (bp_mode != BP_DELAY_SLOT);

    // Training is independent of stall so EX outcomes are never lost
    assign w_bht_upd    = ex_br_valid && (bp_mode == BP_DYNAMIC);

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_rd_idx    (r_pc[IDX_W+1:2]),
        .o_rd_taken  (w_bht_taken),
        .i_upd_en    (w_bht_upd),
        .i_upd_idx   (ex_br_pc[IDX_W+1:2]),
        .i_upd_taken (ex_br_taken)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc      <= RESET_PC;
            r_ifir    <= 32'd0;
            r_id_pc4  <= 32'd0;
            r_id_pred <= 1'b0;
            r_mis_cnt <= 16'd0;
        end else begin
            if (w_mispredict) begin
                r_pc      <= w_fix_pc;
                r_ifir    <= 32'd0;
                r_id_pc4  <= 32'd0;
                r_id_pred <= 1'b0;
                if (r_mis_cnt != 16'hFFFF) begin
                    r_mis_cnt <= r_mis_cnt + 16'd1;
                end
            end else if (!stall) begin
                r_pc      <= w_next_pc;
                r_ifir    <= imem_rdata;
                r_id_pc4  <= w_pc4;
                r_id_pred <= w_beq_redirect;
            end
        end
    end

    assign pc             = r_pc;
    assign imem_addr      = r_pc;
    assign ifir           = r_ifir;
    assign id_pc4         = r_id_pc4;
    assign id_pred_taken  = r_id_pred;
    assign mispredict_cnt = r_mis_cnt;

endmodule

// File: tb/tb_ifetch_predict.sv
module tb_ifetch_predict;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  bp_mode = 2'b00;
    logic        stall = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        ex_br_valid = 1'b0;
    logic        ex_br_taken = 1'b0;
    logic [31:0] ex_br_pc = 32'd0;
    logic [31:0] ex_br_target = 32'd0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] pc;
    logic [31:0] ifir;
    logic [31:0] id_pc4;
    logic        id_pred_taken;
    logic        flush_id;
    logic [15:0] mispredict_cnt;

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    assign imem_rdata = mem[pc[9:2]];

    ifetch_predict #(
        .BHT_ENTRIES (16),
        .RESET_PC    (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bp_mode        (bp_mode),
        .stall          (stall),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .ex_br_valid    (ex_br_valid),
        .ex_br_taken    (ex_br_taken),
        .ex_br_pc       (ex_br_pc),
        .ex_br_target   (ex_br_target),
        .ex_pred_taken  (ex_pred_taken),
        .pc             (pc),
        .ifir           (ifir),
        .id_pc4         (id_pc4),
        .id_pred_taken  (id_pred_taken),
        .flush_id       (flush_id),
        .mispredict_cnt (mispredict_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ifir;
        logic [31:0] pc4;
        logic        pred;
        logic [31:0] cnt;
        logic        flush;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    logic [31:0] m_pc, m_ifir, m_pc4;
    logic        m_pred;
    int          m_cnt;
    int          m_bht[16];

    localparam logic [31:0] BEQ20 = {6'b000100, 5'd1, 5'd2, 16'd16}; // at 20 -> 88
    localparam logic [31:0] J6    = {6'b000010, 26'd6};               // -> 24
    localparam logic [31:0] J5    = {6'b000010, 26'd5};               // -> 20

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ifir = 32'h0; m_pc4 = 32'h0; m_pred = 1'b0; m_cnt = 0;
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
    endtask

    // One cycle of stimulus: drive in the low phase, predict the post-edge state
    task automatic step(input logic [1:0] md, input logic st, input logic v, input logic tk,
                        input logic [31:0] bpc, input logic [31:0] tgt, input logic pd);
        exp_t        e;
        logic [31:0] ins, nxt, p4;
        int          imm, ridx, uidx;
        bit          pbeq, mis, isb, isj;
        @(negedge clk);
        bp_mode = md; stall = st; ex_br_valid = v; ex_br_taken = tk;
        ex_br_pc = bpc; ex_br_target = tgt; ex_pred_taken = pd;
        n_vec++;
        ins  = mem[m_pc[9:2]];
        ridx = int'((m_pc >> 2) % 32'd16);
        uidx = int'((bpc >> 2) % 32'd16);
        if (md == 2'd1)      pbeq = 1'b1;
        else if (md == 2'd3) pbeq = (m_bht[ridx] >= 2);
        else                 pbeq = 1'b0;
        mis     = v && (tk != pd);
        e.flush = mis && (md != 2'd2);
        if (mis) begin
            if (m_cnt < 65535) m_cnt++;
            m_pc = tk ? tgt : bpc + 32'd4;
            m_ifir = 32'd0; m_pc4 = 32'd0; m_pred = 1'b0;
        end else if (!st) begin
            isb = (ins[31:26] == 6'd4);
            isj = (ins[31:26] == 6'd2);
            p4  = m_pc + 32'd4;
            nxt = p4;
            if (isj) begin
                nxt = (p4 & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
            end else if (isb && pbeq) begin
                imm = $signed(ins[15:0]);
                nxt = p4 + 32'(imm * 4);
            end
            m_ifir = ins; m_pc4 = p4; m_pred = isb && pbeq; m_pc = nxt;
        end
        if (v && md == 2'd3) begin
            if (tk) m_bht[uidx] = (m_bht[uidx] == 3) ? 3 : m_bht[uidx] + 1;
            else    m_bht[uidx] = (m_bht[uidx] == 0) ? 0 : m_bht[uidx] - 1;
        end
        e.pc = m_pc; e.ifir = m_ifir; e.pc4 = m_pc4; e.pred = m_pred; e.cnt = 32'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic nop_steps(input logic [1:0] md, input int n);
        for (int i = 0; i < n; i++) step(md, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        ex_br_valid = 1'b0; stall = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_ifir", ifir, 32'h0);
        chk("rst_id_pc4", id_pc4, 32'h0);
        chk("rst_id_pred", id_pred_taken, 1'b0);
        chk("rst_cnt", mispredict_cnt, 32'h0);
        chk("rst_flush", flush_id, 1'b0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    // Monitor: flush_id sampled mid low-phase, registered outputs just after the edge
    logic obs_flush;
    always @(negedge clk) begin
        #3 obs_flush = flush_id;
    end

    initial begin
        exp_t me;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                me = exp_q.pop_front();
                chk("pc", pc, me.pc);
                chk("imem_addr", imem_addr, me.pc);
                chk("ifir", ifir, me.ifir);
                chk("id_pc4", id_pc4, me.pc4);
                chk("id_pred_taken", id_pred_taken, me.pred);
                chk("mispredict_cnt", mispredict_cnt, me.cnt);
                chk("flush_id", obs_flush, me.flush);
            end
        end
    end

    initial begin
        logic [31:0] ins;
        logic [1:0]  md;
        logic [31:0] bpc, tgt;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[5]  = BEQ20;
        mem[19] = J6;
        mem[22] = J5;

        // Reset asynchronously while running at pc 40
        do_reset();
        nop_steps(2'd0, 10);
        after_edge();
        chk("pc_at_40", pc, 32'd40);
        do_reset();

        // Mode 00: beq at 20 resolves taken -> mispredict
        nop_steps(2'd0, 6);
        step(2'd0, 1'b0, 1'b1, 1'b1, 32'd20, 32'd88, 1'b0);
        #1 chk("m00_flush", flush_id, 1'b1);
        after_edge();
        chk("m00_pc", pc, 32'd88);
        chk("m00_ifir", ifir, 32'd0);
        chk("m00_cnt", mispredict_cnt, 32'd1);

        // Mode 01: static taken, zero-bubble redirect, then not-taken resolution
        do_reset();
        nop_steps(2'd1, 6);
        after_edge();
        chk("m01_pc", pc, 32'd88);
        chk("m01_pred", id_pred_taken, 1'b1);
        chk("m01_ifir", ifir, BEQ20);
        step(2'd1, 1'b0, 1'b1, 1'b0, 32'd20, 32'd88, 1'b1);
        #1 chk("m01_flush", flush_id, 1'b1);
        after_edge();
        chk("m01_fix_pc", pc, 32'd24);

        // Mode 10: delay slot preserved
        do_reset();
        nop_steps(2'd2, 6);
        step(2'd2, 1'b0, 1'b1, 1'b1, 32'd20, 32'd88, 1'b0);
        #1 chk("m10_flush", flush_id, 1'b0);
        after_edge();
        chk("m10_ifir", ifir, 32'd0);
        chk("m10_pc", pc, 32'd88);

        // Mode 11: counter 01 -> 10 -> 11 -> 10, prediction taken after first update
        do_reset();
        nop_steps(2'd3, 6);
        after_edge();
        chk("m11_pred0", id_pred_taken, 1'b0);
        step(2'd3, 1'b0, 1'b1, 1'b1, 32'd20, 32'd88, 1'b0);
        nop_steps(2'd3, 2);
        after_edge();
        chk("m11_pred1", id_pred_taken, 1'b1);
        chk("m11_pc1", pc, 32'd88);
        step(2'd3, 1'b0, 1'b1, 1'b1, 32'd20, 32'd88, 1'b1);
        step(2'd3, 1'b0, 1'b1, 1'b0, 32'd20, 32'd88, 1'b1);
        after_edge();
        chk("m11_fix_pc", pc, 32'd24);
        step(2'd3, 1'b0, 1'b1, 1'b1, 32'd100, 32'd20, 1'b0);
        nop_steps(2'd3, 1);
        after_edge();
        chk("m11_pred2", id_pred_taken, 1'b1);

        // j at 76 under stall, then released; mispredict beats stall; wrap-around
        do_reset();
        step(2'd0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd76, 1'b0);
        step(2'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        after_edge();
        chk("j_stall_pc", pc, 32'd76);
        step(2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        after_edge();
        chk("j_pc", pc, 32'd24);
        chk("j_ifir", ifir, J6);
        step(2'd0, 1'b1, 1'b1, 1'b1, 32'd8, 32'd200, 1'b0);
        after_edge();
        chk("mis_over_stall", pc, 32'd200);
        step(2'd0, 1'b0, 1'b1, 1'b1, 32'd8, 32'hFFFF_FFFC, 1'b0);
        nop_steps(2'd0, 1);
        after_edge();
        chk("pc_wrap", pc, 32'd0);

        // Randomized program and EX traffic against the reference model
        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: ins = {6'b000100, 10'($urandom), 16'($signed($urandom_range(0, 63)) - 32)};
                3:       ins = {6'b000010, 26'($urandom_range(0, 255))};
                default: begin
                    ins = $urandom;
                    if (ins[31:26] == 6'd2 || ins[31:26] == 6'd4) ins[31:26] = 6'h23;
                end
            endcase
            mem[i] = ins;
        end
        md = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) md = 2'($urandom_range(0, 3));
            if (i == 1500) do_reset();
            bpc = $urandom & 32'h0000_03FC;
            tgt = ($urandom_range(0, 19) == 0) ? ($urandom | 32'hFFFF_FF00) & 32'hFFFF_FFFC
                                              : $urandom & 32'h0000_03FC;
            step(md, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 1'($urandom), bpc, tgt, 1'($urandom));
        end
        after_edge();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_predict.md
# ifetch_predict

Instruction-fetch stage for the 5-stage pipelined MIPS core: owns the PC register, drives the instruction-memory read port, predicts `beq`/`j` at fetch time, and loads the IF/ID pipeline register (PC+4, IFIR, prediction bit). It sits directly upstream of the ID stage. It accepts branch resolutions from EX to redirect, flush and train. It supports the core's four branch strategies, selected by a 2-bit mode input.

## Interface
- `BHT_ENTRIES`, 16, entries in the 2-bit branch history table (power of 2, indexed by PC[log2+1:2])
- `RESET_PC`, 32'h0, PC value loaded on reset
- `clk` in 1 — rising-edge clock
- `rst` in 1 — asynchronous, active-low reset
- `bp_mode` in 2 — strategy: 00 not-taken, 01 static taken, 10 delay slot (predict not-taken, slot preserved), 11 dynamic BHT
- `stall` in 1 — from hazard unit; hold PC and IF/ID
- `imem_addr` out 32 — equals `pc`
- `imem_rdata` in 32 — combinational read of `imem_addr`
- `ex_br_valid` in 1 — a `beq` is resolving in EX this cycle
- `ex_br_taken` in 1 — actual outcome
- `ex_br_pc` in 32 — address of the resolving `beq`
- `ex_br_target` in 32 — computed taken target
- `ex_pred_taken` in 1 — prediction that travelled with that `beq`
- `pc` out 32 — current fetch PC
- `ifir` out 32 — IF/ID instruction
- `id_pc4` out 32 — IF/ID PC+4
- `id_pred_taken` out 1 — IF/ID prediction bit
- `flush_id` out 1 — combinational; ID/EX must load a bubble this cycle
- `mispredict_cnt` out 16 — saturating mispredict counter

## Operation
- Predecode `imem_rdata`: opcode 000100 = `beq`, 000010 = `j`.
- `j` target: {pc+4[31:28], instr[25:0], 2'b00}. `j` always redirects at fetch in every mode.
- `beq` target: pc+4 + (sign-extended imm16 << 2).
- Prediction for `beq`: 0 in modes 00 and 10; 1 in mode 01; BHT[pc index][1] in mode 11.
- Next-PC priority, highest first:
  - (1) reset
  - (2) mispredict = `ex_br_valid` && (`ex_br_taken` != `ex_pred_taken`); PC ← `ex_br_taken` ? `ex_br_target` : `ex_br_pc`+4
  - (3) `stall`: hold
  - (4) predicted-taken `beq` or `j`: target
  - (5) pc+4
- On mispredict:
  - IF/ID loads a bubble: `ifir`=0, `id_pred_taken`=0, `id_pc4`=0.
  - `flush_id`=1, except in mode 10, where the ID instruction is the delay slot and `flush_id`=0.
  - A mispredict overrides a simultaneous `stall`.
- BHT: `BHT_ENTRIES` 2-bit saturating counters.
  - Reset value 01 (weakly not-taken).
  - On every `ex_br_valid` in mode 11, the entry at `ex_br_pc` is incremented if taken and decremented if not, saturating at 00 and 11.
  - The table does not train in other modes.
- `mispredict_cnt` increments on each mispredict and saturates at 16'hFFFF.
- Reset (async, rst=0):
  - `pc`=`RESET_PC`; `ifir`=0; `id_pc4`=0; `id_pred_taken`=0; `mispredict_cnt`=0; BHT all 01.
  - `flush_id` is 0 whenever `ex_br_valid`=0.

## Timing
- Fetch latency is 1 cycle: the instruction at `pc` appears on `ifir` after the next rising edge.
- Fetch-time redirect (`j`, predicted-taken `beq`) costs 0 bubbles; the fall-through slot is never fetched.
- Mispredict resolved in EX costs 2 bubbles (1 in mode 10):
  - Corrected `pc` is visible the cycle after `ex_br_valid`.
  - `ifir`=0 in that same cycle.
- Stall holds `pc`, `ifir`, `id_pc4` and `id_pred_taken` bit-for-bit; BHT training still occurs during stall.
- A BHT update and a read of the same index in the same cycle return the pre-update value.
- Reset mid-operation clears all state immediately; the first fetch after deassertion is from `RESET_PC`.
- PC arithmetic wraps modulo 2^32 with no error.

## Structure
- A shared package holds: opcode constants (OP_BEQ, OP_J), the bp_mode encodings, and a BHT counter typedef.
- Sub-module `bht_2bit`: counter array with read index, update index and taken input.

## Test plan
- Reset with rst=0 while pc=40 → `pc`=0, `ifir`=0, `mispredict_cnt`=0 asynchronously; first fetch after release is from 0.
- Mode 00, `beq` at 20 with imm 16, resolved taken → `pc`=88 the cycle after `ex_br_valid`, `ifir`=0, `flush_id`=1, `mispredict_cnt`=1.
- Mode 01, same `beq` fetched:
  - Next `pc`=88 with no bubble.
  - If resolved not-taken → `pc`=24, `flush_id`=1.
- Mode 10, mispredict → `flush_id`=0 (delay slot kept), `ifir`=0.
- Mode 11, one `beq` resolves taken twice then not-taken → counter 01→10→11→10; prediction flips to taken after the first update.
- `j` to word 6 (at pc 76) with `stall`=1 in the same cycle → `pc` holds 76; with `stall`=0 the next `pc` is 24. Mispredict with `stall`=1 → redirect wins.
